// File: rtl/hack_memory.sv
// hack_memory: Hack CPU data memory with RAM, LED register, button state and a clear-on-read press latch.
// Define HACK_MEM_DEBOUNCE_EN to insert a per-button debounce filter after the synchroniser.
module hack_memory #(
    parameter int WIDTH           = 16,
    parameter int ADDR_W          = 12,
    parameter int RAM_DEPTH       = 2048,
    parameter int N_LED           = 4,
    parameter int N_BTN           = 2,
    parameter int READ_PHASE      = 5,
    parameter int WRITE_PHASE     = 10,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic              CLK_100MHz,
    input  logic              RST_N,
    input  logic              CLK_CPU,
    input  logic [31:0]       CLK_COUNT,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [WIDTH-1:0]  DATA_W,
    input  logic              LOAD_M,
    output logic [WIDTH-1:0]  DATA_R,
    output logic [N_LED-1:0]  LED,
    input  logic [N_BTN-1:0]  BUTTON,
    output logic              ADDR_ERR
);

    localparam int RAM_AW = $clog2(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] LED_ADDR       = ADDR_W'(RAM_DEPTH);
    localparam logic [ADDR_W-1:0] BTN_STATE_ADDR = ADDR_W'(RAM_DEPTH + 1);
    localparam logic [ADDR_W-1:0] BTN_PRESS_ADDR = ADDR_W'(RAM_DEPTH + 2);

    logic [WIDTH-1:0]  mem [RAM_DEPTH];
    logic [RAM_AW-1:0] ram_idx;
    logic              rd_stb;
    logic              wr_stb;
    logic              is_ram;
    logic              is_oor;
    logic [WIDTH-1:0]  rd_data;
    logic [N_BTN-1:0]  sync1;
    logic [N_BTN-1:0]  sync2;
    logic [N_BTN-1:0]  filt;
    logic [N_BTN-1:0]  filt_q;
    logic [N_BTN-1:0]  press;
    logic [N_BTN-1:0]  press_clr;

    assign rd_stb    = CLK_CPU && (CLK_COUNT == 32'(READ_PHASE));
    assign wr_stb    = CLK_CPU && (CLK_COUNT == 32'(WRITE_PHASE)) && LOAD_M;
    assign is_ram    = ADDRESS < LED_ADDR;
    assign is_oor    = ADDRESS > BTN_PRESS_ADDR;
    assign ram_idx   = ADDRESS[RAM_AW-1:0];
    assign press_clr = {N_BTN{rd_stb && (ADDRESS == BTN_PRESS_ADDR)}};

    always_comb begin
        rd_data = '0;
        if (is_ram)
            rd_data = mem[ram_idx];
        else if (ADDRESS == LED_ADDR)
            rd_data = WIDTH'(LED);
        else if (ADDRESS == BTN_STATE_ADDR)
            rd_data = WIDTH'(filt);
        else if (ADDRESS == BTN_PRESS_ADDR)
            rd_data = WIDTH'(press);
    end

    // RAM has no reset so it can map onto block RAM; reading before the write gives read-before-write.
    always_ff @(posedge CLK_100MHz) begin
        if (RST_N && wr_stb && is_ram)
            mem[ram_idx] <= DATA_W;
    end

    always_ff @(posedge CLK_100MHz) begin
        if (!RST_N) begin
            DATA_R   <= '0;
            LED      <= '0;
            ADDR_ERR <= 1'b0;
            sync1    <= '0;
            sync2    <= '0;
            filt_q   <= '0;
            press    <= '0;
        end else begin
            sync1  <= BUTTON;
            sync2  <= sync1;
            filt_q <= filt;
            // a new rising edge wins over a simultaneous clearing read
            press  <= (press & ~press_clr) | (filt & ~filt_q);
            if (rd_stb)
                DATA_R <= rd_data;
            if (wr_stb && (ADDRESS == LED_ADDR))
                LED <= DATA_W[N_LED-1:0];
            if ((rd_stb || wr_stb) && is_oor)
                ADDR_ERR <= 1'b1;
        end
    end

`ifdef HACK_MEM_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt [N_BTN];

    always_ff @(posedge CLK_100MHz) begin
        if (!RST_N) begin
            filt <= '0;
            for (int i = 0; i < N_BTN; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (sync2[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    filt[i] <= sync2[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end
`else
    logic unused_debounce;

    assign filt            = sync2;
    assign unused_debounce = ^32'(DEBOUNCE_CYCLES);
`endif

endmodule

// File: doc/hack_memory.md
# hack_memory

Parametrised data-memory block for the Hack CPU: on-chip RAM plus memory-mapped LED output, synchronised button input and a clear-on-read button-press latch. Reads and writes are issued on programmable CPU clock phases relative to the 100 MHz system clock. The block sits between the CPU data port and the board I/O, and is the drop-in successor of the fixed 2K data memory.

## Interface
Parameters:
- WIDTH, 16, data word width.
- ADDR_W, 12, address width; must satisfy 2^ADDR_W ≥ RAM_DEPTH+3.
- RAM_DEPTH, 2048, RAM words at addresses 0..RAM_DEPTH-1.
- N_LED, 4, LED outputs (≤ WIDTH).
- N_BTN, 2, button inputs (≤ WIDTH).
- READ_PHASE, 5, CLK_COUNT value at which a read is sampled.
- WRITE_PHASE, 10, CLK_COUNT value at which a write is committed.
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a button change is accepted (10 ms at 100 MHz).

Ports:
- CLK_100MHz  in  1  system clock; all logic on its rising edge.
- RST_N  in  1  synchronous reset, active-low.
- CLK_CPU  in  1  CPU clock level, used as a phase qualifier.
- CLK_COUNT  in  32  system-clock count within the CPU cycle.
- ADDRESS  in  ADDR_W  word address.
- DATA_W  in  WIDTH  write data.
- LOAD_M  in  1  write enable.
- DATA_R  out  WIDTH  registered read data.
- LED  out  N_LED  LED register.
- BUTTON  in  N_BTN  raw asynchronous buttons.
- ADDR_ERR  out  1  sticky out-of-range access flag.

## Operation
- Strobes: rd_stb = (CLK_COUNT==READ_PHASE && CLK_CPU); wr_stb = (CLK_COUNT==WRITE_PHASE && CLK_CPU && LOAD_M).
- Address map: 0..RAM_DEPTH-1 RAM; RAM_DEPTH = LED; RAM_DEPTH+1 = BTN_STATE; RAM_DEPTH+2 = BTN_PRESS; above that is out of range.
- RAM: wr_stb writes DATA_W. Contents are not reset; they are zero at configuration.
- LED: wr_stb writes DATA_W[N_LED-1:0]. Reads return the value zero-extended.
- BTN_STATE: read-only; returns the filtered button vector zero-extended. Writes are ignored.
- BTN_PRESS: per-bit latch. A bit is set on a 0→1 transition of the filtered button. rd_stb at this address returns the latch and clears it. If a set and a clear occur in the same cycle, the set wins (bit stays 1). Writes are ignored.
- Out of range: reads return 0; writes are dropped; either access type sets ADDR_ERR, which stays set until reset.
- When rd_stb is inactive, DATA_R holds its value.
- Reset values: DATA_R=0, LED=0, ADDR_ERR=0, BTN_PRESS=0, filtered buttons=0, synchroniser=0, debounce counters=0.

## Timing
- Read latency: DATA_R is valid on the clock edge after the rd_stb cycle (1 system clock).
- Write commit: the new value is visible on the edge of the wr_stb cycle. A read strobe in the same cycle (READ_PHASE==WRITE_PHASE) returns the old data (read-before-write).
- Button path: 2-flop synchroniser, then the filter stage. The filter adds 0 or DEBOUNCE_CYCLES cycles, depending on configuration.
- BTN_PRESS is set 1 cycle after the filtered rising edge.
- RST_N low is sampled on the clock edge. Reset mid-debounce clears the counters. A strobe coinciding with reset is ignored: no write occurs, DATA_R=0, and ADDR_ERR stays 0.

## Configuration
- HACK_MEM_DEBOUNCE_EN defined: each button bit has a counter sized $clog2(DEBOUNCE_CYCLES+1).
  - The counter increments while the synchronised bit differs from the filtered bit and resets to 0 when they match.
  - At DEBOUNCE_CYCLES the filtered bit takes the new value and the counter clears.
- Undefined: the filtered bit equals the synchroniser output (latency 2 cycles); no counters are instantiated.

## Test plan
- Write then read RAM: wr_stb with ADDRESS=0x123, DATA_W=0xBEEF, then rd_stb at 0x123 -> DATA_R=0xBEEF one cycle after the strobe; address 0x124 still reads 0.
- LED map: write 0xFFFF to 2048 -> LED=4'hF; read 2048 -> DATA_R=0x000F.
- Strobe gating: LOAD_M=1 with CLK_COUNT=9 or CLK_CPU=0 -> RAM unchanged; DATA_R unchanged between read strobes.
- Button press latch (debounce disabled): BUTTON 00→01 -> BTN_STATE=0x0001 within 3 cycles; first BTN_PRESS read=0x0001, second read=0x0000. Also cover a new edge coinciding with the clearing read -> bit remains 1.
- Debounce (enabled, DEBOUNCE_CYCLES=8): a 5-cycle glitch -> BTN_STATE stays 0. A 10-cycle high pulse -> BTN_STATE=1 at sync+8 cycles.
- Out-of-range and reset: write to 2051 -> RAM/LED unchanged, ADDR_ERR=1; read 2051 -> DATA_R=0. RST_N low for one cycle -> ADDR_ERR=0, LED=0, DATA_R=0, RAM contents preserved.
